// File: rtl/dsam_if.sv
// DSAM receive-side bus: encoded words in, reconstructed samples out.
// Optional channel tag (ch_idx) is present when DSAM_DEC_CHANNEL_TAG_EN is defined.
interface dsam_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 256
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in;
    logic                  sync;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out;
`ifdef DSAM_DEC_CHANNEL_TAG_EN
    localparam int PW = $clog2(CHANNELS);
    logic [PW-1:0]         ch_idx;
`endif

`ifdef DSAM_DEC_CHANNEL_TAG_EN
    modport master (output in_valid, in, sync, input out_valid, out, ch_idx);
    modport slave  (input in_valid, in, sync, output out_valid, out, ch_idx);
`else
    modport master (output in_valid, in, sync, input out_valid, out);
    modport slave  (input in_valid, in, sync, output out_valid, out);
`endif
endinterface

// File: rtl/dsam_decoder.sv
// DSAM decoder: undoes XOR-chain correlation and per-channel differencing.
// Optional macro DSAM_DEC_CHANNEL_TAG_EN adds a registered ch_idx output.
module dsam_decoder #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 256
) (
    input  logic   clk,
    input  logic   reset,
    dsam_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int PW = $clog2(CHANNELS);

    typedef enum logic [0:0] {WARMUP = 1'b0, STEADY = 1'b1} state_t;

    state_t          state_q, state_d, state_eff_s;
    logic [PW-1:0]   ptr_q, ptr_d, ptr_eff_s;
    logic [W-2:0]    c_prev_q, c_prev_d, c_eff_s;
    logic [W-1:0]    out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   ch_idx_q, ch_idx_d;
    logic [W-2:0]    m_s;
    logic [W-1:0]    s_s, x_s, hist_rd_s;
    logic            hist_we_s;
    logic [W-1:0]    hist_q [CHANNELS];

    // sync clears the stream state combinationally so a word arriving with it decodes as k=0
    always_comb begin
        state_eff_s = bus.sync ? WARMUP : state_q;
        ptr_eff_s   = bus.sync ? '0 : ptr_q;
        c_eff_s     = bus.sync ? '0 : c_prev_q;
        hist_rd_s   = hist_q[ptr_eff_s];
        m_s         = bus.in[W-2:0] ^ c_eff_s;
        if (bus.in[W-1]) begin
            m_s = ~m_s;
        end else begin
            m_s = m_s;
        end
        s_s = {bus.in[W-1], m_s};
        x_s = (state_eff_s == STEADY) ? (hist_rd_s - s_s) : s_s;
    end

    // Next-state and output computation; idle cycles only carry the sync clear forward
    always_comb begin
        state_d     = state_eff_s;
        ptr_d       = ptr_eff_s;
        c_prev_d    = c_eff_s;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ch_idx_d    = ch_idx_q;
        hist_we_s   = 1'b0;
        if (bus.in_valid) begin
            c_prev_d    = bus.in[W-2:0];
            out_d       = x_s;
            out_valid_d = 1'b1;
            ch_idx_d    = ptr_eff_s;
            hist_we_s   = 1'b1;
            if (ptr_eff_s == PW'(CHANNELS - 1)) begin
                ptr_d   = '0;
                state_d = STEADY;
            end else begin
                ptr_d   = ptr_eff_s + PW'(1);
            end
        end else begin
            hist_we_s   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WARMUP;
            ptr_q       <= '0;
            c_prev_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ch_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            c_prev_q    <= c_prev_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ch_idx_q    <= ch_idx_d;
        end
    end

    // History store has no reset: every slot is written during warm-up before it is read
    always_ff @(posedge clk) begin
        if (!reset && hist_we_s) begin
            hist_q[ptr_eff_s] <= x_s;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
`ifdef DSAM_DEC_CHANNEL_TAG_EN
    assign bus.ch_idx    = ch_idx_q;
`else
    logic unused_ch_s;
    assign unused_ch_s = ^ch_idx_q;
`endif
endmodule

// File: tb/tb_dsam_decoder.sv
// Bench for dsam_decoder: directed vectors on CHANNELS=4, then randomized streams
// on CHANNELS=4/5/256 checked against a golden encoder model.
module tb_dsam_decoder;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dsam_if #(.DATA_WIDTH(16), .CHANNELS(4))   b4 ();
    dsam_if #(.DATA_WIDTH(16), .CHANNELS(5))   b5 ();
    dsam_if #(.DATA_WIDTH(16), .CHANNELS(256)) b256 ();

    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(4))   d4   (.clk(clk), .reset(reset), .bus(b4));
    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(5))   d5   (.clk(clk), .reset(reset), .bus(b5));
    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(256)) d256 (.clk(clk), .reset(reset), .bus(b256));

    typedef struct {
        logic        sync;
        logic [15:0] e;
        logic [15:0] x;
    } vec_t;

    vec_t vecs [11];

    // golden encoder model state, per instance
    int          cs [3] = '{4, 5, 256};
    int          k  [3];
    logic [14:0] cprev [3];
    logic [15:0] xs [3][0:16383];
    logic        ev [3];
    logic [15:0] eo [3];
    int          ech [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int i, input logic s, input logic v, input logic [15:0] e);
        case (i)
            0: begin b4.sync = s;   b4.in_valid = v;   b4.in = e;   end
            1: begin b5.sync = s;   b5.in_valid = v;   b5.in = e;   end
            default: begin b256.sync = s; b256.in_valid = v; b256.in = e; end
        endcase
    endtask

    task automatic sample(input int i, output logic v, output logic [15:0] o, output int ch);
        ch = 0;
        case (i)
            0: begin v = b4.out_valid; o = b4.out;
`ifdef DSAM_DEC_CHANNEL_TAG_EN
                ch = int'(b4.ch_idx);
`endif
            end
            1: begin v = b5.out_valid; o = b5.out;
`ifdef DSAM_DEC_CHANNEL_TAG_EN
                ch = int'(b5.ch_idx);
`endif
            end
            default: begin v = b256.out_valid; o = b256.out;
`ifdef DSAM_DEC_CHANNEL_TAG_EN
                ch = int'(b256.ch_idx);
`endif
            end
        endcase
    endtask

    // encode x as the next word of stream i; expected decoder output is x itself
    task automatic encode(input int i, input logic [15:0] x, output logic [15:0] e);
        logic [15:0] s;
        logic [14:0] c;
        s = (k[i] < cs[i]) ? x : 16'(xs[i][k[i] - cs[i]] - x);
        c = (s[15] ? ~s[14:0] : s[14:0]) ^ cprev[i];
        e = {s[15], c};
        cprev[i] = c;
        xs[i][k[i]] = x;
        ech[i] = k[i] % cs[i];
        k[i]++;
    endtask

    // directed step on the C=4 instance: drive at negedge, check the registered result one cycle later
    task automatic apply(input logic s, input logic v, input logic [15:0] e,
                         input logic exp_v, input logic [15:0] exp_o, input string name);
        logic        ov;
        logic [15:0] oo;
        int          och;
        drive(0, s, v, e);
        @(negedge clk);
        sample(0, ov, oo, och);
        chk({name, ".valid"}, 32'(ov), 32'(exp_v));
        chk({name, ".out"}, 32'(oo), 32'(exp_o));
    endtask

    function automatic logic [15:0] rand_sample();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) begin
            case ($urandom_range(0, 3))
                0: return 16'h0000;
                1: return 16'h8000;
                2: return 16'hFFFF;
                default: return 16'h7FFF;
            endcase
        end
        return 16'($urandom);
    endfunction

    initial begin
        logic        ov;
        logic [15:0] oo, e, x, last;
        int          och, valid_cnt;
        logic        v, s;

        vecs = '{
            '{1'b0, 16'h000A, 16'd10}, '{1'b0, 16'h001E, 16'd20},
            '{1'b0, 16'h0000, 16'd30}, '{1'b0, 16'h0028, 16'd40},
            '{1'b0, 16'h002B, 16'd7},  '{1'b0, 16'h802F, 16'd25},
            '{1'b1, 16'h0063, 16'd99}, '{1'b0, 16'h0062, 16'd1},
            '{1'b0, 16'h0060, 16'd2},  '{1'b0, 16'h0063, 16'd3},
            '{1'b0, 16'h8063, 16'd100}
        };

        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 16'h0000);
        drive(0, 1'b0, 1'b1, 16'h1234);

        // reset held 3 cycles with a word offered, then released idle
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sample(0, ov, oo, och);
            chk("reset.valid", 32'(ov), 32'd0);
            chk("reset.out", 32'(oo), 32'd0);
        end
        reset = 1'b0;
        apply(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, "post_reset");

        // warm-up, steady sign path, sync restart with further warm-up and a steady word
        for (int i = 0; i < 11; i++)
            apply(vecs[i].sync, 1'b1, vecs[i].e, 1'b1, vecs[i].x, $sformatf("vec%0d", i));

        // sync alone clears the stream but leaves out holding
        apply(1'b1, 1'b0, 16'h0000, 1'b0, 16'd100, "sync_idle");

        // same stream as the first six vectors, with random gaps
        last = 16'd100;
        valid_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 1'b1, vecs[i].e, 1'b1, vecs[i].x, $sformatf("gap_vec%0d", i));
            valid_cnt++;
            last = vecs[i].x;
            for (int g = 0; g < int'($urandom_range(1, 3)); g++)
                apply(1'b0, 1'b0, 16'hDEAD, 1'b0, last, $sformatf("gap_hold%0d", i));
        end
        chk("gap_count", 32'(valid_cnt), 32'd6);
        drive(0, 1'b0, 1'b0, 16'h0000);

        // random streams on all three widths with golden encoder model
        for (int it = 0; it < 12000; it++) begin
            if (it > 0) begin
                for (int i = 0; i < 3; i++) begin
                    sample(i, ov, oo, och);
                    chk($sformatf("rnd%0d.valid", cs[i]), 32'(ov), 32'(ev[i]));
                    chk($sformatf("rnd%0d.out", cs[i]), 32'(oo), 32'(eo[i]));
`ifdef DSAM_DEC_CHANNEL_TAG_EN
                    chk($sformatf("rnd%0d.ch_idx", cs[i]), 32'(och), 32'(ech[i]));
`endif
                end
            end
            reset = (it < 2) || (it == 6000) || (it == 6001);
            for (int i = 0; i < 3; i++) begin
                v = ($urandom_range(0, 9) < 8);
                s = ($urandom_range(0, 2999) == 0);
                x = rand_sample();
                if (reset) begin
                    k[i] = 0; cprev[i] = '0;
                    ev[i] = 1'b0; eo[i] = 16'h0000; ech[i] = 0;
                    drive(i, s, v, x);
                end else begin
                    if (s) begin
                        k[i] = 0; cprev[i] = '0;
                    end
                    if (v) begin
                        encode(i, x, e);
                        ev[i] = 1'b1; eo[i] = x;
                        drive(i, s, 1'b1, e);
                    end else begin
                        ev[i] = 1'b0;
                        drive(i, s, 1'b0, x);
                    end
                end
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
